intr_dispatch_sched: RTL and testbench

//  Services interrupts presented by intr_ctrl (intr_valid_o/intr_to_service_o) by dispatching each one
//  to one of NUM_HDL service handlers, chosen round-robin among enabled handlers.

---
 rtl/intr_pkg.sv | 20 ++
 rtl/intr_dispatch_sched_if.sv | 31 +++
 rtl/intr_rr_arb.sv | 35 +++
 rtl/intr_dispatch_sched.sv | 150 +++++++++++++++
 tb/tb_intr_dispatch_sched.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt dispatch scheduler.
package intr_pkg;

  localparam int unsigned DEF_IDX_W   = 4;
  localparam int unsigned DEF_NUM_HDL = 4;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    OFFER,
    BUSY,
    COMPLETE,
    GUARD
  } disp_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/intr_dispatch_sched_if.sv
// Handler-side dispatch bus: enable mask, one-hot request, id, ack and done.
interface intr_dispatch_sched_if
  import intr_pkg::*;
#(
  parameter int unsigned NUM_HDL = DEF_NUM_HDL,
  parameter int unsigned IDX_W   = DEF_IDX_W
);

  logic [NUM_HDL-1:0] hdl_en_i;
  logic [NUM_HDL-1:0] hdl_req_o;
  logic [IDX_W-1:0]   hdl_id_o;
  logic [NUM_HDL-1:0] hdl_ack_i;
  logic [NUM_HDL-1:0] hdl_done_i;

  modport master (
    input  hdl_en_i,
    input  hdl_ack_i,
    input  hdl_done_i,
    output hdl_req_o,
    output hdl_id_o
  );

  modport slave (
    output hdl_en_i,
    output hdl_ack_i,
    output hdl_done_i,
    input  hdl_req_o,
    input  hdl_id_o
  );

endinterface

// File: rtl/intr_rr_arb.sv
// Combinational round-robin pick: first set mask bit at or after ptr, wrapping.
module intr_rr_arb #(
  parameter int unsigned NUM_HDL = 4
) (
  input  logic [NUM_HDL-1:0]         mask,
  input  logic [$clog2(NUM_HDL)-1:0] ptr,
  output logic [NUM_HDL-1:0]         grant,
  output logic [$clog2(NUM_HDL)-1:0] grant_idx,
  output logic                       any_valid
);

  localparam int unsigned PTR_W = $clog2(NUM_HDL);

  always_comb begin
    int unsigned k;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    k         = 0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_HDL; i++) begin
      // ptr is always < NUM_HDL, so one subtraction implements the wrap
      k = 32'(ptr) + i;
      if (k >= NUM_HDL) k = k - NUM_HDL;
      idx = PTR_W'(k);
      if (!any_valid && mask[idx]) begin
        any_valid   = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/intr_dispatch_sched.sv
// Dispatches intr_ctrl interrupts to round-robin handlers with timeout and bounded retry.
module intr_dispatch_sched
  import intr_pkg::*;
#(
  parameter int unsigned NUM_HDL     = DEF_NUM_HDL,
  parameter int unsigned IDX_W       = DEF_IDX_W,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned MAX_RETRY   = 1
) (
  input  logic                 pclk_i,
  input  logic                 prst_n_i,
  input  logic                 intr_valid_i,
  input  logic [IDX_W-1:0]     intr_to_service_i,
  output logic                 intr_serviced_o,
  output logic                 intr_active_o,
  intr_dispatch_sched_if.master hdl,
  output logic                 timeout_o,
  output logic                 drop_o,
  output logic [7:0]           err_cnt_o
);

  localparam int unsigned PTR_W = $clog2(NUM_HDL);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

  disp_state_e        state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_q;
  logic [IDX_W-1:0]   id_q;
  logic [NUM_HDL-1:0] excl;
  logic [RTY_W-1:0]   retry;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         err_cnt;
  logic [NUM_HDL-1:0] req_q;
  logic               serviced_q;
  logic               active_q;
  logic               timeout_q;
  logic               drop_q;

  logic [NUM_HDL-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [PTR_W-1:0]   rr_next;

  intr_rr_arb #(
    .NUM_HDL (NUM_HDL)
  ) u_arb (
    .mask      (hdl.hdl_en_i & ~excl),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  assign rr_next = (arb_idx == PTR_W'(NUM_HDL - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      id_q       <= '0;
      excl       <= '0;
      retry      <= '0;
      timer      <= '0;
      err_cnt    <= '0;
      req_q      <= '0;
      serviced_q <= 1'b0;
      active_q   <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      serviced_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (intr_valid_i) begin
            id_q  <= intr_to_service_i;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (arb_any) begin
            req_q    <= arb_grant;
            gnt_q    <= arb_idx;
            rr_ptr   <= rr_next;
            active_q <= 1'b1;
            state    <= OFFER;
          end
        end
        OFFER: begin
          // an ack in the same cycle the enable falls still wins
          if (hdl.hdl_ack_i[gnt_q]) begin
            req_q <= '0;
            timer <= '0;
            state <= BUSY;
          end else if (!hdl.hdl_en_i[gnt_q]) begin
            req_q       <= '0;
            excl[gnt_q] <= 1'b1;
            active_q    <= 1'b0;
            state       <= SELECT;
          end
        end
        BUSY: begin
          if (hdl.hdl_done_i[gnt_q]) begin
            serviced_q <= 1'b1;
            active_q   <= 1'b0;
            state      <= COMPLETE;
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout_q   <= 1'b1;
            err_cnt     <= sat_inc8(err_cnt);
            excl[gnt_q] <= 1'b1;
            active_q    <= 1'b0;
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= SELECT;
            end else begin
              drop_q     <= 1'b1;
              serviced_q <= 1'b1;
              state      <= COMPLETE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COMPLETE: begin
          state <= GUARD;
        end
        GUARD: begin
          excl  <= '0;
          retry <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign hdl.hdl_req_o    = req_q;
  assign hdl.hdl_id_o     = id_q;
  assign intr_serviced_o  = serviced_q;
  assign intr_active_o    = active_q;
  assign timeout_o        = timeout_q;
  assign drop_o           = drop_q;
  assign err_cnt_o        = err_cnt;

endmodule

// File: tb/tb_intr_dispatch_sched.sv
// Randomized transaction-level bench for intr_dispatch_sched against a round-robin/retry model.
module tb_intr_dispatch_sched;

  localparam int NH = 4;
  localparam int TO = 64;

  localparam int M_RAND     = 0;
  localparam int M_COMPLETE = 1;
  localparam int M_RETRY_OK = 2;
  localparam int M_HANG     = 3;

  localparam int B_COMPLETE = 0;
  localparam int B_HANG     = 1;
  localparam int B_DISABLE  = 2;

  logic       clk;
  logic       rst_n;
  logic       intr_valid;
  logic [3:0] intr_id;
  logic       serviced;
  logic       active;
  logic       timeout;
  logic       drop;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;
  int m_err    = 0;

  intr_dispatch_sched_if #(.NUM_HDL(NH), .IDX_W(4)) hdl_bus ();

  intr_dispatch_sched #(
    .NUM_HDL     (NH),
    .IDX_W       (4),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (1)
  ) dut (
    .pclk_i            (clk),
    .prst_n_i          (rst_n),
    .intr_valid_i      (intr_valid),
    .intr_to_service_i (intr_id),
    .intr_serviced_o   (serviced),
    .intr_active_o     (active),
    .hdl               (hdl_bus.master),
    .timeout_o         (timeout),
    .drop_o            (drop),
    .err_cnt_o         (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input logic [3:0] en, input logic [3:0] ex, input int rr);
    for (int i = 0; i < NH; i++) begin
      int k = (rr + i) % NH;
      if (en[k] && !ex[k]) return k;
    end
    return -1;
  endfunction

  task automatic run_intr(input logic [3:0] id, input logic [3:0] en, input int mode);
    logic [3:0] ex;
    logic [3:0] onehot;
    int retry;
    int g;
    int beh;
    int n;
    int d;
    bit fin;
    ex  = '0;
    retry = 0;
    fin = 1'b0;
    hdl_bus.hdl_en_i = en;
    intr_valid = 1'b1;
    intr_id    = id;
    tick();
    intr_id = 4'($urandom);
    while (!fin) begin
      g = pick(hdl_bus.hdl_en_i, ex, m_rr);
      if (g < 0) begin
        for (int i = 0; i < 3; i++) begin
          check_eq("sel_wait_req", 32'(hdl_bus.hdl_req_o), 32'd0);
          check_eq("sel_wait_svc", 32'(serviced), 32'd0);
          check_eq("sel_wait_act", 32'(active), 32'd0);
          tick();
        end
        hdl_bus.hdl_en_i = 4'hF;
        g = pick(hdl_bus.hdl_en_i, ex, m_rr);
      end
      tick();
      onehot = 4'(1 << g);
      m_rr   = (g + 1) % NH;
      check_eq("offer_req", 32'(hdl_bus.hdl_req_o), 32'(onehot));
      check_eq("offer_id", 32'(hdl_bus.hdl_id_o), 32'(id));
      check_eq("offer_act", 32'(active), 32'd1);

      case (mode)
        M_COMPLETE: beh = B_COMPLETE;
        M_RETRY_OK: beh = (retry == 0) ? B_HANG : B_COMPLETE;
        M_HANG:     beh = B_HANG;
        default: begin
          n = $urandom_range(0, 19);
          if (n < 3 && ex == 4'b0 && pick(hdl_bus.hdl_en_i, onehot, 0) >= 0) beh = B_DISABLE;
          else if (n < 8) beh = B_HANG;
          else beh = B_COMPLETE;
        end
      endcase

      if (beh == B_DISABLE) begin
        hdl_bus.hdl_en_i[g] = 1'b0;
        tick();
        check_eq("dis_req", 32'(hdl_bus.hdl_req_o), 32'd0);
        check_eq("dis_act", 32'(active), 32'd0);
        ex[g] = 1'b1;
        hdl_bus.hdl_en_i[g] = 1'b1;
        continue;
      end

      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        hdl_bus.hdl_ack_i  = 4'($urandom) & ~onehot;
        hdl_bus.hdl_done_i = 4'($urandom);
        tick();
        check_eq("hold_req", 32'(hdl_bus.hdl_req_o), 32'(onehot));
        check_eq("hold_id", 32'(hdl_bus.hdl_id_o), 32'(id));
        check_eq("hold_svc", 32'(serviced), 32'd0);
      end
      hdl_bus.hdl_ack_i  = onehot;
      hdl_bus.hdl_done_i = '0;
      tick();
      hdl_bus.hdl_ack_i = '0;
      check_eq("busy_req", 32'(hdl_bus.hdl_req_o), 32'd0);
      check_eq("busy_act", 32'(active), 32'd1);

      if (beh == B_COMPLETE) begin
        d = ($urandom_range(0, 5) == 0) ? TO - 1 : $urandom_range(0, 20);
        for (int i = 0; i < d; i++) begin
          hdl_bus.hdl_done_i = 4'($urandom) & ~onehot;
          tick();
          check_eq("busy_svc", 32'(serviced), 32'd0);
          check_eq("busy_to", 32'(timeout), 32'd0);
        end
        hdl_bus.hdl_done_i = onehot;
        tick();
        hdl_bus.hdl_done_i = '0;
        check_eq("done_svc", 32'(serviced), 32'd1);
        check_eq("done_drop", 32'(drop), 32'd0);
        check_eq("done_to", 32'(timeout), 32'd0);
        check_eq("done_act", 32'(active), 32'd0);
        fin = 1'b1;
      end else begin
        n = 0;
        while (timeout == 1'b0 && n < 200) begin
          tick();
          n++;
        end
        check_eq("timeout_lat", 32'(n), 32'(TO));
        m_err = (m_err < 255) ? m_err + 1 : 255;
        ex[g] = 1'b1;
        if (retry < 1) begin
          retry++;
          check_eq("retry_drop", 32'(drop), 32'd0);
          check_eq("retry_svc", 32'(serviced), 32'd0);
          check_eq("retry_act", 32'(active), 32'd0);
        end else begin
          check_eq("drop_pulse", 32'(drop), 32'd1);
          check_eq("drop_svc", 32'(serviced), 32'd1);
          fin = 1'b1;
        end
      end
    end
    intr_valid = 1'b0;
    tick();
    check_eq("guard_svc", 32'(serviced), 32'd0);
    check_eq("guard_drop", 32'(drop), 32'd0);
    check_eq("guard_to", 32'(timeout), 32'd0);
    tick();
    check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
    check_eq("idle_act", 32'(active), 32'd0);
    check_eq("idle_req", 32'(hdl_bus.hdl_req_o), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    rst_n = 1'b0;
    intr_valid = 1'b0;
    intr_id = '0;
    hdl_bus.hdl_en_i   = '0;
    hdl_bus.hdl_ack_i  = '0;
    hdl_bus.hdl_done_i = '0;
    @(negedge clk);
    check_eq("rst_req", 32'(hdl_bus.hdl_req_o), 32'd0);
    check_eq("rst_id", 32'(hdl_bus.hdl_id_o), 32'd0);
    check_eq("rst_svc", 32'(serviced), 32'd0);
    check_eq("rst_act", 32'(active), 32'd0);
    check_eq("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    run_intr(4'd5, 4'hF, M_COMPLETE);
    for (int i = 1; i <= 4; i++) run_intr(4'(i), 4'hF, M_COMPLETE);
    run_intr(4'd7, 4'b0100, M_COMPLETE);
    run_intr(4'd8, 4'b0000, M_COMPLETE);
    run_intr(4'd9, 4'hF, M_RETRY_OK);

    hdl_bus.hdl_en_i = 4'hF;
    intr_valid = 1'b1;
    intr_id = 4'd3;
    tick();
    tick();
    g = pick(4'hF, 4'h0, m_rr);
    check_eq("arst_pre_req", 32'(hdl_bus.hdl_req_o), 32'(1 << g));
    hdl_bus.hdl_ack_i = 4'(1 << g);
    tick();
    hdl_bus.hdl_ack_i = '0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(hdl_bus.hdl_req_o), 32'd0);
    check_eq("arst_id", 32'(hdl_bus.hdl_id_o), 32'd0);
    check_eq("arst_svc", 32'(serviced), 32'd0);
    check_eq("arst_act", 32'(active), 32'd0);
    check_eq("arst_to", 32'(timeout), 32'd0);
    check_eq("arst_drop", 32'(drop), 32'd0);
    check_eq("arst_err", 32'(err_cnt), 32'd0);
    intr_valid = 1'b0;
    repeat (2) begin
      tick();
      check_eq("arst_hold_svc", 32'(serviced), 32'd0);
    end
    rst_n = 1'b1;
    m_rr  = 0;
    m_err = 0;
    tick();
    run_intr(4'd6, 4'hF, M_COMPLETE);
    run_intr(4'd10, 4'hF, M_HANG);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] en;
      en = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
      run_intr(4'($urandom), en, M_RAND);
    end
    for (int i = 0; i < 130; i++) run_intr(4'($urandom), 4'hF, M_HANG);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
